// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues fetches, registers the
// returned instruction for decode, and handles redirects. Optional macro: ALIGN_CHECK_EN.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap
);

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FETCH,
    ST_HOLD
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, instr_pc_next;
  logic        instr_valid_next;
  logic        trap_next;
  logic [31:0] redirect_pc;
  logic        misaligned;

`ifdef ALIGN_CHECK_EN
  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target;
`else
  // Low address bits are simply dropped so the PC always stays word aligned.
  assign misaligned  = 1'b0;
  assign redirect_pc = redirect_target & ~32'h3;
`endif

  assign imem_addr = pc;
  assign pc_plus4  = instr_pc + 32'd4;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    trap_next        = 1'b0;
    imem_req         = 1'b0;

    unique case (state)
      ST_RESET: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = !(instr_valid && stall);
        if (redirect_valid) begin
          pc_next          = redirect_pc;
          instr_valid_next = 1'b0;
          trap_next        = misaligned;
        end else if (instr_valid && stall) begin
          state_next = ST_HOLD;
        end else if (imem_ready) begin
          instr_next       = imem_rdata;
          instr_pc_next    = pc;
          instr_valid_next = 1'b1;
          pc_next          = pc + 32'd4;
        end else begin
          // Decode took the previous word; nothing new arrived to replace it.
          instr_valid_next = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_next       = ST_FETCH;
          pc_next          = redirect_pc;
          instr_valid_next = 1'b0;
          trap_next        = misaligned;
        end else if (!stall) begin
          state_next       = ST_FETCH;
          instr_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      pc          <= RESET_VECTOR;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_next;
  end
  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_next;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what decode should see, expressed as the fetch stage's visible state.
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_held, m_started, m_trap;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .pc_plus4        (pc_plus4),
    .misalign_trap   (misalign_trap)
  );

  function automatic void model_reset();
    m_pc = RESET_VECTOR; m_instr = 0; m_ipc = 0;
    m_valid = 0; m_held = 0; m_started = 0; m_trap = 0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare every output
  // against the model, then advance the model across the rising edge.
  task automatic step(input bit rv, input logic [31:0] rt, input bit st, input bit rdy);
    bit          exp_req;
    logic [31:0] data;
    @(negedge clk);
    redirect_valid  = rv;
    redirect_target = rt;
    stall           = st;
    imem_ready      = rdy;
    imem_rdata      = $urandom;
    data            = imem_rdata;
    #1;
    exp_req = m_started && !m_held && !(m_valid && st);
    n_checks += 7;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req: got %b expected %b", imem_req, exp_req);
    end
    if (imem_addr !== m_pc) begin
      n_fail++; $display("FAIL imem_addr: got %h expected %h", imem_addr, m_pc);
    end
    if (instr_valid !== m_valid) begin
      n_fail++; $display("FAIL instr_valid: got %b expected %b", instr_valid, m_valid);
    end
    if (instr !== m_instr) begin
      n_fail++; $display("FAIL instr: got %h expected %h", instr, m_instr);
    end
    if (instr_pc !== m_ipc) begin
      n_fail++; $display("FAIL instr_pc: got %h expected %h", instr_pc, m_ipc);
    end
    if (pc_plus4 !== m_ipc + 32'd4) begin
      n_fail++; $display("FAIL pc_plus4: got %h expected %h", pc_plus4, m_ipc + 32'd4);
    end
    if (misalign_trap !== m_trap) begin
      n_fail++; $display("FAIL misalign_trap: got %b expected %b", misalign_trap, m_trap);
    end
    @(posedge clk);
    m_trap = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (rv) begin
      if (ALIGN && rt[1:0] != 2'b00) begin
        m_pc   = TRAP_VECTOR;
        m_trap = 1;
      end else begin
        m_pc = {rt[31:2], 2'b00};
      end
      m_valid = 0;
      m_held  = 0;
    end else if (m_held) begin
      if (!st) begin
        m_held  = 0;
        m_valid = 0;
      end
    end else if (m_valid && st) begin
      m_held = 1;
    end else if (rdy) begin
      m_instr = data;
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; redirect_valid = 0; redirect_target = 0;
    stall = 0; imem_ready = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    if (imem_addr !== RESET_VECTOR) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_VECTOR); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h/%h expected 0/0", instr, instr_pc); end
    if (misalign_trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", misalign_trap); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      n_checks += 2;
      if (imem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 4 * (i + 1)); end
      if (instr_pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin
        n_fail++; $display("FAIL seq_ipc: got %h/%h expected %h/%h", instr_pc, pc_plus4, 4 * i, 4 * i + 4);
      end
    end
  endtask

  task automatic test_wait();
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL wait_hold: got addr %h valid %b expected 8/0", imem_addr, instr_valid);
      end
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (instr_pc !== 32'h8 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL wait_done: got ipc %h valid %b expected 8/1", instr_pc, instr_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 1);
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || imem_addr !== 32'h8) begin
        n_fail++; $display("FAIL stall_frozen: got valid %b ipc %h addr %h expected 1/4/8", instr_valid, instr_pc, imem_addr);
      end
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL stall_bubble: got valid %b addr %h expected 0/8", instr_valid, imem_addr);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (instr_pc !== 32'h8 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume: got ipc %h valid %b expected 8/1", instr_pc, instr_valid);
    end
  endtask

  task automatic test_redirect();
    step(1, 32'h200, 0, 1);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL redir_fetch: got valid %b addr %h expected 0/200", instr_valid, imem_addr);
    end
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(1, 32'h200, 1, 1);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL redir_hold: got valid %b addr %h expected 0/200", instr_valid, imem_addr);
    end
    step(0, 0, 1, 1);
  endtask

  task automatic test_wrap();
    step(1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 1);
    n_checks++;
    if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap: got addr %h ipc %h p4 %h expected 0/fffffffc/0", imem_addr, instr_pc, pc_plus4);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_VECTOR || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got req %b addr %h valid %b expected 0/0/0", imem_req, imem_addr, instr_valid);
    end
    do_reset();
    step(0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    step(0, 0, 0, 1);
    step(1, 32'h202, 0, 1);
    n_checks++;
    if (imem_addr !== (ALIGN ? TRAP_VECTOR : 32'h200) || misalign_trap !== ALIGN || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL misalign: got addr %h trap %b valid %b expected %h/%b/0",
                         imem_addr, misalign_trap, instr_valid, ALIGN ? TRAP_VECTOR : 32'h200, ALIGN);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(7) == 0, $urandom, $urandom_range(2) == 0, $urandom_range(3) != 0);
    end
  endtask

  initial begin
    rst_n = 0; redirect_valid = 0; redirect_target = 0;
    stall = 0; imem_ready = 0; imem_rdata = 0;
    model_reset();
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle processor. Holds the architectural PC, issues fetch requests to instruction memory, registers the returned instruction for decode, and computes the sequential next PC (PC + 4) that feeds the next-PC selection path. Branch and jump redirects from execute override sequential flow. A decode stall freezes the fetched instruction.

## Interface

- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (only when ALIGN_CHECK_EN is defined).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- stall  input  1  decode cannot accept the instruction; hold outputs.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  imem_rdata valid for the current request this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr  output  32  registered instruction to decode.
- instr_pc  output  32  PC of instr.
- pc_plus4  output  32  instr_pc + 4, modulo 2^32, combinational from instr_pc.
- misalign_trap  output  1  one-cycle pulse on a misaligned redirect.

## Operation

- States: RESET, FETCH, HOLD.
- While rst_n=0: state=RESET, pc=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, misalign_trap=0, imem_req=0.
- RESET -> FETCH on the first rising edge after rst_n deasserts. imem_req stays 0 in RESET.
- FETCH:
  - imem_req = !(instr_valid && stall).
  - When imem_req && imem_ready: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  - When imem_req && !imem_ready: the request is held, with the same address next cycle.
  - When instr_valid && stall: -> HOLD.
- HOLD:
  - imem_req=0; instr, instr_pc and instr_valid are frozen.
  - -> FETCH when stall=0. The held instruction is consumed that cycle, and instr_valid<=0 at that edge, which gives a one-cycle bubble.
- Redirect (FETCH or HOLD):
  - redirect_valid has priority over imem_ready, stall and HOLD.
  - Actions: pc<=redirect_target, instr_valid<=0 (flush), state->FETCH.
  - Any imem_rdata returned in the same cycle is discarded.
- Sequential PC arithmetic is 32-bit unsigned with wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- An asynchronous reset mid-fetch drops the request immediately (imem_req=0 combinationally), with no response pending.

## Timing

- Fetch latency: imem_ready=1 at edge N gives instr_valid=1 and the new instr after edge N.
- Throughput: one instruction per cycle while imem_ready=1, stall=0 and there is no redirect.
- Redirect sampled at edge N: imem_addr=redirect_target during cycle N+1, and instr_valid=0 during cycle N+1.
- First fetch after reset: rst_n rises before edge 0; imem_req=1 with imem_addr=RESET_VECTOR after edge 0.
- misalign_trap is registered: high for exactly the one cycle following the offending redirect edge.

## Configuration

- Macro: ALIGN_CHECK_EN.
- Defined: when redirect_valid is set and redirect_target[1:0]!=0, the block does three things instead of the normal redirect:
  - pc<=TRAP_VECTOR.
  - instr_valid<=0.
  - misalign_trap pulses for one cycle.
- Undefined: redirect_target[1:0] is forced to 2'b00 when loaded into pc, and misalign_trap is tied to 0.

## Test plan

- Reset then imem_ready=1 continuously with stall=0 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_pc lags imem_addr by one cycle; pc_plus4 = instr_pc+4.
- imem_ready=0 for 3 cycles at addr 0x8 -> imem_addr stays 0x8 and instr_valid stays 0 in those cycles; with imem_ready=1 on the 4th cycle, instr_pc=0x8 next cycle.
- stall=1 for 2 cycles while instr_valid=1, instr_pc=0x4 -> HOLD, imem_req=0, outputs frozen; stall=0 -> instr_valid=0 for one cycle, then the fetch of 0x8 resumes.
- redirect_valid=1, target 0x200, coincident with imem_ready=1 -> returned data discarded, instr_valid=0 next cycle, imem_addr=0x200; the same check repeated in HOLD.
- PC at 0xFFFF_FFFC with a fetch completing -> next imem_addr=0x0; also assert rst_n low mid-request -> imem_req=0 immediately, pc=RESET_VECTOR.
- With ALIGN_CHECK_EN, redirect to 0x202 -> misalign_trap=1 for one cycle and imem_addr=0x100. Without ALIGN_CHECK_EN -> imem_addr=0x200 and misalign_trap=0.
